fft_mem_ctrl: RTL and testbench
===============================

# fft_mem_ctrl

Frame sequencer and arbiter for the shared single-port sample RAM in the tuner pipeline. Each frame runs three phases in order: loader fill (bit-reversed sample writes), in-place FFT, spectrum readout. The block owns the RAM port and multiplexes it to exactly one requester per phase. A low-priority host/debug read port gets the RAM only while the block is idle.

## Interface
- ADDR_W, 11, RAM address width
- DATA_W, 10, RAM data width
- N_SAMPLES, 1024, writes that complete the load phase
- TIMEOUT_CYCLES, 65535, per-phase watchdog limit (used only with the macro)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one frame; sampled in IDLE only
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on READ→IDLE
- error  out  1  sticky watchdog flag; cleared by reset or an accepted start
- load_go  out  1  level; drives the loader's do_load
- load_we / load_addr / load_data  in  1 / ADDR_W / DATA_W  loader write port
- load_done  in  1  loader data_loaded
- load_count  out  ADDR_W  writes accepted in the current frame
- fft_start  out  1  one-cycle pulse on entering FFT
- fft_we / fft_addr / fft_wdata  in  1 / ADDR_W / DATA_W  FFT engine port
- fft_done  in  1  FFT engine finished
- rd_go  out  1  level; readout owns the RAM
- rd_addr  in  ADDR_W  readout address
- rd_done  in  1  readout finished
- host_req / host_addr  in  1 / ADDR_W  debug read request
- host_gnt  out  1  host owns the RAM this cycle
- mem_addr / mem_wdata / mem_we  out  ADDR_W / DATA_W / 1  registered RAM port

## Operation
- States: IDLE, LOAD, FFT, READ.
- IDLE
  - start=1 → LOAD; load_count←0; error←0.
  - Otherwise host_gnt = host_req, and mem_addr←host_addr.
- LOAD
  - load_go=1; the RAM port follows the loader.
  - Each load_we increments load_count.
  - Exit to FFT on load_done=1, or on the cycle that load_count reaches N_SAMPLES, whichever comes first.
- FFT
  - fft_start pulses in the first FFT cycle.
  - The RAM port follows the FFT engine.
  - fft_done → READ.
- READ
  - rd_go=1; mem_addr←rd_addr; mem_we=0.
  - rd_done → IDLE, with a frame_done pulse.
- Inputs from a requester that does not own the port are ignored. In particular, a load_we outside LOAD never reaches mem_we and never counts.
- load_count saturates at N_SAMPLES and holds its value until the next accepted start.
- In FFT and READ, mem_wdata holds its last value.
- The block never reorders addresses; bit reversal is the loader's job.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts immediately, with mem_we=0 on that same edge. No partial frame resumes after reset.
- Port latency: mem_addr, mem_wdata and mem_we are registered copies of the owning requester's inputs, one clk after them.
- State transitions take effect on the edge after the condition. The first owned cycle of a new phase drives from the new owner.
- start while busy=1 is ignored (not queued).
- start and host_req in the same IDLE cycle: start wins, host_gnt=0.
- host_gnt is combinational from host_req and the IDLE state. It drops in the cycle the state leaves IDLE.
- load_done and a final load_we in the same cycle: the write is issued and counted, then the state goes to FFT.
- fft_done in the same cycle as fft_start is legal; FFT then lasts exactly 1 cycle.
- load_go and rd_go drop on the exit edge of their phase.

## Configuration
- FFT_MEM_CTRL_TIMEOUT_EN defined:
  - A per-phase counter clears on every state change.
  - If LOAD, FFT or READ lasts TIMEOUT_CYCLES cycles, the state returns to IDLE and error←1.
  - No frame_done pulse is issued; mem_we is forced to 0.
- Macro undefined:
  - No counter is built; error is tied to 0.
  - Phases wait indefinitely.

## Test plan
- Full frame:
  - Stimulus: start pulse; 1024 load_we, addr bit-reversed 0..1023, data k*250; fft_done 50 cycles after fft_start; rd_done 1024 cycles after rd_go.
  - Required: mem_we count=1024; load_count=1024; one fft_start; one frame_done; busy low afterwards.
- Early load_done:
  - Stimulus: load_done asserted with the 300th load_we.
  - Required: load_count=300; FFT entered on the next edge; the 301st write attempt gives mem_we=0.
- Arbitration:
  - Stimulus: host_req=1, host_addr=0x155 in IDLE, then start in the same cycle as host_req.
  - Required: mem_addr=0x155 while idle; on start, host_gnt=0; in READ, mem_addr follows rd_addr with mem_we=0.
- Foreign writes:
  - Stimulus: fft_we pulses during LOAD; load_we pulses during FFT.
  - Required: none appear on mem_we; load_count unchanged.
- Reset mid-FFT:
  - Stimulus: rst_n low for 2 cycles during FFT.
  - Required: all outputs 0 immediately; state IDLE; the next start runs a clean frame with load_count from 0.
- Watchdog (macro on, TIMEOUT_CYCLES=100):
  - Stimulus: fft_done never arrives.
  - Required: 100 cycles after fft_start, error=1 and busy=0 with no frame_done; the next start clears error.

Source files
------------

// File: rtl/fft_mem_ctrl.sv
// ============================================================================
// Module   : fft_mem_ctrl
// Purpose  : Frame sequencer and arbiter for the shared single-port sample
//            RAM. It steps each frame through loader fill, in-place FFT and
//            spectrum readout, and hands the RAM port to one requester per
//            phase. While idle, a host/debug read port may use the RAM.
// Options  : FFT_MEM_CTRL_TIMEOUT_EN - adds a per-phase watchdog that sends
//            the block back to IDLE and sets a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_mem_ctrl #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 10,
    parameter int N_SAMPLES      = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output logic              load_go,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [ADDR_W-1:0] load_count,
    output logic              fft_start,
    input  logic              fft_we,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_wdata,
    input  logic              fft_done,
    output logic              rd_go,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FFT  = 2'd2,
        S_READ = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] COUNT_MAX  = ADDR_W'(N_SAMPLES);
    localparam logic [ADDR_W-1:0] COUNT_LAST = ADDR_W'(N_SAMPLES - 1);

    state_t state;
    state_t state_next;
    logic   timeout;
    logic   load_last;

    // The write that brings the count to N_SAMPLES closes the load phase on
    // the same edge it is issued, just like a load_done arriving with it.
    assign load_last = load_we && (load_count == COUNT_LAST);

    assign busy     = (state != S_IDLE);
    assign load_go  = (state == S_LOAD);
    assign rd_go    = (state == S_READ);
    // start wins over a simultaneous host request.
    assign host_gnt = (state == S_IDLE) && host_req && !start;

`ifdef FFT_MEM_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] PHASE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] phase_cnt;

    assign timeout = (state != S_IDLE) && (phase_cnt == PHASE_LAST);

    // Cycles spent in the current phase; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= '0;
        end else if (state != S_IDLE) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Sticky watchdog flag, cleared only by reset or an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (state == S_IDLE && start) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign error              = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one phase after another, watchdog overrides all.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start)                  state_next = S_LOAD;
            S_LOAD: if (load_done || load_last) state_next = S_FFT;
            S_FFT:  if (fft_done)               state_next = S_READ;
            S_READ: if (rd_done)                state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
        if (timeout) begin
            state_next = S_IDLE;
        end
    end

    // Registered RAM port muxed from the current owner, plus the load
    // counter and the single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            load_count <= '0;
            fft_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            fft_start  <= (state == S_LOAD) && (state_next == S_FFT);
            frame_done <= (state == S_READ) && rd_done && !timeout;
            case (state)
                S_IDLE: begin
                    if (host_gnt) begin
                        mem_addr <= host_addr;
                    end
                    if (start) begin
                        load_count <= '0;
                    end
                end
                S_LOAD: begin
                    mem_addr  <= load_addr;
                    mem_wdata <= load_data;
                    mem_we    <= load_we && !timeout;
                    if (load_we && load_count != COUNT_MAX) begin
                        load_count <= load_count + 1'b1;
                    end
                end
                S_FFT: begin
                    mem_addr  <= fft_addr;
                    mem_wdata <= fft_wdata;
                    mem_we    <= fft_we && !timeout;
                end
                S_READ: begin
                    mem_addr <= rd_addr;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_mem_ctrl.sv
// ============================================================================
// Module   : tb_fft_mem_ctrl
// Purpose  : Directed self-checking bench for fft_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_mem_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              error;
    logic              load_go;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic [ADDR_W-1:0] load_count;
    logic              fft_start;
    logic              fft_we;
    logic [ADDR_W-1:0] fft_addr;
    logic [DATA_W-1:0] fft_wdata;
    logic              fft_done;
    logic              rd_go;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int fs_cnt   = 0;
    int fd_cnt   = 0;
    int we0, fs0, fd0;

    fft_mem_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SAMPLES(1024), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .frame_done(frame_done), .error(error), .load_go(load_go),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .load_count(load_count), .fft_start(fft_start),
        .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
        .fft_done(fft_done), .rd_go(rd_go), .rd_addr(rd_addr),
        .rd_done(rd_done), .host_req(host_req), .host_addr(host_addr),
        .host_gnt(host_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (mem_we)     we_cnt++;
        if (fft_start)  fs_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] bitrev10(input int k);
        logic [9:0] v;
        logic [9:0] r;
        v = 10'(k);
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return {1'b0, r};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        fft_we = 1'b0; fft_addr = '0; fft_wdata = '0; fft_done = 1'b0;
        rd_addr = '0; rd_done = 1'b0; host_req = 1'b0; host_addr = '0;

        // ---- reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_error", error, 0);
        check("rst_load_go", load_go, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_rd_go", rd_go, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_load_count", load_count, 0);
        rst_n = 1'b1;
        tick();

        // ---- arbitration in IDLE
        host_req = 1'b1; host_addr = 11'h155;
        #1;
        check("host_gnt_idle", host_gnt, 1);
        tick();
        check("host_mem_addr", mem_addr, 11'h155);
        check("host_mem_we", mem_we, 0);
        start = 1'b1;
        #1;
        check("host_gnt_vs_start", host_gnt, 0);
        we0 = we_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
        tick();
        start = 1'b0; host_req = 1'b0;
        check("load_busy", busy, 1);
        check("load_go_high", load_go, 1);
        check("load_count_zero", load_count, 0);
        check("host_gnt_busy", host_gnt, 0);

        // ---- full frame: 1024 bit-reversed writes, one foreign fft_we gap
        for (int k = 0; k < 1024; k++) begin
            if (k == 500) begin
                load_we = 1'b0; fft_we = 1'b1; fft_addr = 11'h3;
                tick();
                check("foreign_fft_we", mem_we, 0);
                check("foreign_fft_cnt", load_count, 500);
                fft_we = 1'b0;
            end
            load_we = 1'b1; load_addr = bitrev10(k); load_data = DATA_W'(k * 250);
            tick();
            if (k == 0) begin
                check("k0_addr", mem_addr, 0);
                check("k0_we", mem_we, 1);
            end
            if (k == 777) begin
                check("k777_addr", mem_addr, 579);
                check("k777_data", mem_wdata, 714);
                check("k777_cnt", load_count, 778);
            end
        end
        check("full_load_count", load_count, 1024);
        check("full_fft_start", fft_start, 1);
        check("full_load_go", load_go, 0);
        check("full_last_we", mem_we, 1);

        // FFT cycle 0: a stray loader write must be ignored
        tick();
        load_we = 1'b0;
        check("foreign_load_we", mem_we, 0);
        check("foreign_load_cnt", load_count, 1024);
        check("fft_start_pulse", fft_start, 0);
        // FFT cycles 1..3: engine writes
        for (int c = 1; c <= 3; c++) begin
            fft_we = 1'b1; fft_addr = ADDR_W'(c + 16); fft_wdata = DATA_W'(10'h2A0 + c);
            tick();
            check("fft_addr", mem_addr, c + 16);
            check("fft_we", mem_we, 1);
        end
        fft_we = 1'b0;
        repeat (46) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("read_rd_go", rd_go, 1);
        check("read_busy", busy, 1);
        for (int r = 0; r < 1024; r++) begin
            rd_addr = ADDR_W'(r);
            rd_done = (r == 1023);
            tick();
            if (r == 5) begin
                check("read_addr", mem_addr, 5);
                check("read_we", mem_we, 0);
                check("read_wdata_hold", mem_wdata, 10'h2A3);
            end
        end
        rd_done = 1'b0;
        check("frame_done_pulse", frame_done, 1);
        check("frame_idle", busy, 0);
        check("frame_rd_go", rd_go, 0);
        tick();
        check("frame_done_drop", frame_done, 0);
        check("frame_we_count", we_cnt - we0, 1027);
        check("frame_fs_count", fs_cnt - fs0, 1);
        check("frame_fd_count", fd_cnt - fd0, 1);
        check("frame_error", error, 0);

        // ---- early load_done with the 300th write
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            load_we = 1'b1; load_addr = ADDR_W'(k); load_done = (k == 300);
            tick();
        end
        check("early_count", load_count, 300);
        check("early_fft_start", fft_start, 1);
        check("early_we300", mem_we, 1);
        check("early_load_go", load_go, 0);
        load_done = 1'b0;
        tick();
        load_we = 1'b0;
        check("early_we301", mem_we, 0);
        check("early_count_hold", load_count, 300);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("early_read", rd_go, 1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("early_frame_done", frame_done, 1);
        tick();

        // ---- reset mid-FFT
        start = 1'b1;
        tick();
        start = 1'b0;
        load_we = 1'b1; load_done = 1'b1;
        tick();
        load_we = 1'b0; load_done = 1'b0;
        fft_we = 1'b1; fft_addr = 11'h7;
        tick();
        check("midfft_we", mem_we, 1);
        check("midfft_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_load_count", load_count, 0);
        check("arst_rd_go", rd_go, 0);
        fft_we = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clean_count0", load_count, 0);
        check("clean_load_go", load_go, 1);
        load_we = 1'b1;
        tick();
        check("clean_count1", load_count, 1);
        load_done = 1'b1;
        tick();
        load_we = 1'b0; load_done = 1'b0;
        check("clean_count2", load_count, 2);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("clean_frame_done", frame_done, 1);
        tick();

`ifdef FFT_MEM_CTRL_TIMEOUT_EN
        // ---- watchdog: fft_done never arrives
        fd0 = fd_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("wd_fft_start", fft_start, 1);
        repeat (99) tick();
        check("wd_still_busy", busy, 1);
        tick();
        check("wd_busy_low", busy, 0);
        check("wd_error", error, 1);
        tick();
        check("wd_no_frame_done", fd_cnt - fd0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_error_clear", error, 0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
`else
        check("error_tied", error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
